// File: rtl/tff_bank_sequencer_if.sv
// Control/status bundle between the counter control logic and the
// TFF bank sequencer. The master drives the run requests and the
// sampled parameters; the slave (the sequencer) reports bank state.
interface tff_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output start, stop, dir, mode, limit,
    input  q, q_bar, t_vec, busy, done, tc
  );

  modport slave (
    input  start, stop, dir, mode, limit,
    output q, q_bar, t_vec, busy, done, tc
  );
endinterface

// File: rtl/tff_bank_sequencer.sv
// Sequencer for a bank of toggle flip-flops used as an up/down counter.
// Every state change of the bank is expressed as a toggle vector
// (q <= q ^ t_vec), including loads, so this block owns all enables.
module tff_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tff_bank_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] start_init;
  logic [WIDTH-1:0] reload_init;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] t_vec_c;
  logic             tc_c;

  // Ripple toggle enables: a bit toggles when all lower bits are ones
  // (counting up) or all lower bits are zeros (counting down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign up_t[gi] = &q_q[gi-1:0];
      assign dn_t[gi] = &(~q_q[gi-1:0]);
    end
  endgenerate

  // Load value for a fresh start uses the live inputs; reloads and the
  // terminal compare use only the values latched at start.
  assign start_init  = bus.dir ? bus.limit : '0;
  assign reload_init = dir_q   ? lim_q     : '0;
  assign end_val     = dir_q   ? '0        : lim_q;

  // Next-state, toggle vector and terminal-count decode.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    t_vec_c = '0;
    tc_c    = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
      lim_d   = '0;
      dir_d   = 1'b0;
      mode_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (q_q == end_val) begin
            tc_c = 1'b1;
            if (mode_q) begin
              t_vec_c = q_q ^ reload_init;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            t_vec_c = dir_q ? dn_t : up_t;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start.
          if (bus.start) begin
            lim_d   = bus.limit;
            dir_d   = bus.dir;
            mode_d  = bus.mode;
            t_vec_c = q_q ^ start_init;
            state_d = ST_RUN;
          end
        end
      endcase
    end
    q_d = rst ? '0 : (q_q ^ t_vec_c);
  end

  // Single register stage for the FSM, the bank and the latched run setup.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    q_q     <= q_d;
    lim_q   <= lim_d;
    dir_q   <= dir_d;
    mode_q  <= mode_d;
  end

  assign bus.q     = q_q;
  assign bus.q_bar = ~q_q;
  assign bus.t_vec = t_vec_c;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.tc    = tc_c;

endmodule

// File: doc/tff_bank_sequencer.md
# tff_bank_sequencer

Sequencer for a bank of `WIDTH` toggle flip-flops, used as a programmable up/down counter. Each cycle it computes a per-bit toggle vector and applies it to the bank (`q <= q ^ t_vec`). It runs a start/stop/done handshake with one-shot or auto-reload modes. It sits between control logic and the TFF-based counter datapath, and is the single owner of every toggle enable.

## Interface
- `WIDTH`, default 4: number of toggle flip-flops in the bank (≥ 2).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a run; honoured in IDLE or DONE only.
- `stop`, in, 1: abort a run; honoured in RUN only.
- `dir`, in, 1: 0 = count up, 1 = count down; sampled on an accepted start.
- `mode`, in, 1: 0 = one-shot, 1 = auto-reload; sampled on an accepted start.
- `limit`, in, `WIDTH`: terminal value; sampled on an accepted start.
- `q`, out, `WIDTH`: bank state (registered).
- `q_bar`, out, `WIDTH`: `~q`.
- `t_vec`, out, `WIDTH`: toggle vector applied at the next edge (combinational from registered state and inputs).
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `tc`, out, 1: terminal-count flag, high for the cycle in which `q` equals the end value in RUN.

## Operation
- States: IDLE, RUN, DONE. Latched registers: `dir_r`, `mode_r`, `lim_r`.
- `init` = 0 when the latched/sampled dir is 0, else `limit`. `end` = `lim_r` when `dir_r` = 0, else 0.
- **IDLE or DONE with `start`=1:**
  - Latch `dir`, `mode`, `limit`.
  - `t_vec = q ^ init` (load expressed as toggles).
  - Go to RUN.
- **IDLE or DONE with `start`=0:** `t_vec` = 0; `q` holds.
- **RUN, priority stop > terminal > count:**
  - **`stop`=1:** `t_vec` = 0; go to IDLE. `tc` is suppressed that cycle even if `q == end`.
  - **`q == end`:** `tc`=1.
    - One-shot: `t_vec` = 0; go to DONE.
    - Auto-reload: `t_vec = q ^ init`; stay in RUN.
  - **Otherwise, count:**
    - Up: `t_vec[0]` = 1; `t_vec[i]` = AND of `q[i-1:0]`.
    - Down: `t_vec[0]` = 1; `t_vec[i]` = AND of `~q[i-1:0]`.
- `start` in RUN is ignored. `stop` outside RUN is ignored.
- Changes to `limit`/`dir`/`mode` during RUN have no effect until the next accepted start.
- The count never wraps: it always halts or reloads at `end`. An up count with `limit` = 2^WIDTH−1 terminates at all-ones.
- `limit` = 0:
  - Both directions: `init == end` = 0, so `tc` fires on the first RUN cycle.
  - One-shot: one RUN cycle, then DONE.
  - Auto-reload: `tc` stays high continuously.
- `rst`=1 overrides everything, including `start` in the same cycle:
  - State → IDLE; `q` → 0; latched registers → 0.
  - `t_vec` is forced to 0 while `rst` = 1.

## Timing
- Reset values: `q`=0, `q_bar`=all ones, `t_vec`=0, `busy`=0, `done`=0, `tc`=0.
- Start accepted at edge n: from cycle n+1, `busy`=1 and `q`=`init`.
- Up, one-shot, `limit`=L:
  - `q` = k in cycle n+1+k.
  - `tc`=1 in cycle n+1+L.
  - From n+2+L: `done`=1, `busy`=0, `q`=L held.
- Down, one-shot, `limit`=L: `q` = L−k in cycle n+1+k; `tc` in cycle n+1+L.
- Auto-reload: period L+1 cycles. `tc` is a one-cycle pulse per period; `q` = `init` on the cycle after `tc`.
- Stop accepted at edge m: from cycle m+1, `busy`=0 and `q` is frozen at its cycle-m value.
- Reset mid-run: the edge after `rst` is sampled high, all outputs are at reset values.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`=1 → `q`=0, `busy`=`done`=`tc`=0, `t_vec`=0 throughout.
- Up, one-shot, `WIDTH`=4, `limit`=5 → `q` 0,1,2,3,4,5; `tc` high only at `q`=5; then `done`=1 and `q` holds at 5 for 3 or more cycles. Check `t_vec`=4'b0011 when `q`=1.
- Down, auto-reload, `limit`=3, run 10 cycles → `q` 3,2,1,0,3,2,1,0,3,2; `tc` pulses at each 0; `busy` stays 1.
- Stop at `q`=2 during an up count to 9, with `start` pulsed mid-run beforehand → `start` ignored; after the stop, `busy`=0 and `q`=2 frozen; a later `start` (up) reloads `q`=0.
- Edges:
  - `limit`=15, up, one-shot: `t_vec`=4'b1111 at 7→8; `tc` at 15; no wrap.
  - `limit`=0, one-shot: `tc` in the first RUN cycle, `done` the next.
  - `limit` changed mid-run: no effect on `end`.
- Reset mid-run: assert `rst` at `q`=6 (up, `limit`=12, auto-reload) → next cycle `q`=0, IDLE; no `tc`.
